// File: rtl/raizing_soundlatch_fifo_pkg.sv
// rtl/raizing_soundlatch_fifo_pkg.sv - shared types and helpers for the 68K/Z80 sound mailbox
package raizing_soundlatch_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam byte_t BYTE_RST = 8'h00;

  // Channel-select width; a single-channel build still gets a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raizing_soundlatch_fifo_if.sv
// rtl/raizing_soundlatch_fifo_if.sv - 68K/Z80 mailbox bus (optional Z80NMI under SOUNDLATCH_NMI_EN)
interface raizing_soundlatch_fifo_if
  import raizing_soundlatch_pkg::*;
#(
  parameter int NCH = 4
);
  localparam int CW = ch_w(NCH);

  logic          MAIN_WE;
  logic [CW-1:0] MAIN_CH;
  byte_t         MAIN_DIN;
  logic          MAIN_RD;
  byte_t         MAIN_DOUT;
  logic [NCH-1:0] MAIN_FULL;
  logic [NCH-1:0] REPLY_VALID;
  logic          SND_RD;
  logic [CW-1:0] SND_CH;
  byte_t         SND_DOUT;
  logic          SND_WE;
  byte_t         SND_DIN;
  logic [NCH-1:0] SND_PENDING;
  logic [NCH-1:0] OVF;
  logic          OVF_CLR;
  logic          INT_ACK;
  logic          Z80INT;
`ifdef SOUNDLATCH_NMI_EN
  logic          Z80NMI;

  modport master (
    output MAIN_WE, MAIN_CH, MAIN_DIN, MAIN_RD, SND_RD, SND_CH, SND_WE, SND_DIN, OVF_CLR, INT_ACK,
    input  MAIN_DOUT, MAIN_FULL, REPLY_VALID, SND_DOUT, SND_PENDING, OVF, Z80INT, Z80NMI
  );
  modport slave (
    input  MAIN_WE, MAIN_CH, MAIN_DIN, MAIN_RD, SND_RD, SND_CH, SND_WE, SND_DIN, OVF_CLR, INT_ACK,
    output MAIN_DOUT, MAIN_FULL, REPLY_VALID, SND_DOUT, SND_PENDING, OVF, Z80INT, Z80NMI
  );
`else
  modport master (
    output MAIN_WE, MAIN_CH, MAIN_DIN, MAIN_RD, SND_RD, SND_CH, SND_WE, SND_DIN, OVF_CLR, INT_ACK,
    input  MAIN_DOUT, MAIN_FULL, REPLY_VALID, SND_DOUT, SND_PENDING, OVF, Z80INT
  );
  modport slave (
    input  MAIN_WE, MAIN_CH, MAIN_DIN, MAIN_RD, SND_RD, SND_CH, SND_WE, SND_DIN, OVF_CLR, INT_ACK,
    output MAIN_DOUT, MAIN_FULL, REPLY_VALID, SND_DOUT, SND_PENDING, OVF, Z80INT
  );
`endif

endinterface

// File: rtl/raizing_soundlatch_fifo_chfifo.sv
// rtl/raizing_soundlatch_fifo_chfifo.sv - single-channel DEPTH x 8 command FIFO with sticky overflow
module raizing_latch_chfifo
  import raizing_soundlatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  logic  ovf_clr,
  input  byte_t din,
  output byte_t dout,
  output logic  full,
  output logic  empty,
  output logic  ovf,
  output logic  accepted,
  output logic  pending_nxt
);
  localparam int PW = $clog2(DEPTH);

  byte_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_nxt;
  logic          do_push, do_pop;

  assign full    = (count == (PW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full channel still takes the push when a pop frees a slot in the same cycle.
  assign do_push = push && (!full || pop);
  assign accepted = do_push;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (!do_push && do_pop)
      count_nxt = count - 1'b1;
  end

  assign pending_nxt = (count_nxt != '0);

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= BYTE_RST;
      ovf    <= 1'b0;
    end else begin
      count <= count_nxt;
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      if (push && full && !pop)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/raizing_soundlatch_fifo.sv
// rtl/raizing_soundlatch_fifo.sv - NCH-channel 68K->Z80 command FIFOs, Z80->68K replies, Z80 interrupt; Z80NMI under SOUNDLATCH_NMI_EN
module raizing_soundlatch_fifo
  import raizing_soundlatch_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DEPTH     = 4,
  parameter int INT_PULSE = 0
) (
  input logic                       CLK,
  input logic                       RESET,
  raizing_soundlatch_fifo_if.slave  bus
);
  localparam int CW = ch_w(NCH);

  logic [NCH-1:0] push_vec, pop_vec, full_vec, empty_vec, ovf_vec, acc_vec, pnd_nxt;
  byte_t          fifo_dout [NCH];
  byte_t          reply     [NCH];
  logic [NCH-1:0] reply_valid;
  logic [CW-1:0]  last_ch;
  byte_t          main_dout, snd_sel, reply_sel;
  logic           z80int, pop_ok;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      push_vec[i] = bus.MAIN_WE && (bus.MAIN_CH == CW'(i));
      pop_vec[i]  = bus.SND_RD  && (bus.SND_CH  == CW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    raizing_latch_chfifo #(.DEPTH(DEPTH)) u_chfifo (
      .clk         (CLK),
      .rst_n       (RESET),
      .push        (push_vec[g]),
      .pop         (pop_vec[g]),
      .ovf_clr     (bus.OVF_CLR),
      .din         (bus.MAIN_DIN),
      .dout        (fifo_dout[g]),
      .full        (full_vec[g]),
      .empty       (empty_vec[g]),
      .ovf         (ovf_vec[g]),
      .accepted    (acc_vec[g]),
      .pending_nxt (pnd_nxt[g])
    );
  end

  assign pop_ok = |(pop_vec & ~empty_vec);

  // SND_DOUT follows the channel of the last successful pop, so an empty pop holds it.
  always_comb begin
    snd_sel   = BYTE_RST;
    reply_sel = BYTE_RST;
    for (int i = 0; i < NCH; i++) begin
      if (last_ch == CW'(i))
        snd_sel = fifo_dout[i];
      if (bus.MAIN_CH == CW'(i))
        reply_sel = reply[i];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_ch     <= '0;
      main_dout   <= BYTE_RST;
      reply_valid <= '0;
      z80int      <= 1'b0;
      for (int i = 0; i < NCH; i++)
        reply[i] <= BYTE_RST;
    end else begin
      if (pop_ok)
        last_ch <= bus.SND_CH;
      if (bus.MAIN_RD)
        main_dout <= reply_sel;
      for (int i = 0; i < NCH; i++) begin
        if (bus.SND_WE && (bus.SND_CH == CW'(i))) begin
          reply[i]       <= bus.SND_DIN;
          reply_valid[i] <= 1'b1;
        end else if (bus.MAIN_RD && (bus.MAIN_CH == CW'(i))) begin
          reply_valid[i] <= 1'b0;
        end
      end
      if (INT_PULSE == 0)
        z80int <= |pnd_nxt;
      else if (|acc_vec)
        z80int <= 1'b1;
      else if (bus.INT_ACK)
        z80int <= 1'b0;
    end
  end

  assign bus.MAIN_DOUT   = main_dout;
  assign bus.SND_DOUT    = snd_sel;
  assign bus.MAIN_FULL   = full_vec;
  assign bus.SND_PENDING = ~empty_vec;
  assign bus.OVF         = ovf_vec;
  assign bus.REPLY_VALID = reply_valid;
  assign bus.Z80INT      = z80int;

`ifdef SOUNDLATCH_NMI_EN
  logic z80nmi;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      z80nmi <= 1'b0;
    else
      z80nmi <= acc_vec[NCH-1];
  end

  assign bus.Z80NMI = z80nmi;
`endif

endmodule

// File: tb/tb_raizing_soundlatch_fifo.sv
// tb/tb_raizing_soundlatch_fifo.sv - directed self-checking bench for the sound mailbox
module tb_raizing_soundlatch_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  raizing_soundlatch_fifo_if #(.NCH(4)) bus0 ();
  raizing_soundlatch_fifo_if #(.NCH(4)) bus1 ();

  raizing_soundlatch_fifo #(.NCH(4), .DEPTH(4), .INT_PULSE(0)) u_lvl (
    .CLK(clk), .RESET(rst_n), .bus(bus0.slave));
  raizing_soundlatch_fifo #(.NCH(4), .DEPTH(4), .INT_PULSE(1)) u_pls (
    .CLK(clk), .RESET(rst_n), .bus(bus1.slave));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus0.MAIN_WE = 0; bus0.MAIN_RD = 0; bus0.SND_RD = 0; bus0.SND_WE = 0;
    bus0.OVF_CLR = 0; bus0.INT_ACK = 0;
    bus1.MAIN_WE = 0; bus1.MAIN_RD = 0; bus1.SND_RD = 0; bus1.SND_WE = 0;
    bus1.OVF_CLR = 0; bus1.INT_ACK = 0;
  endtask

  task automatic push0(input logic [1:0] ch, input logic [7:0] d);
    bus0.MAIN_WE = 1; bus0.MAIN_CH = ch; bus0.MAIN_DIN = d;
    tick(); idle();
  endtask

  task automatic pop0(input logic [1:0] ch);
    bus0.SND_RD = 1; bus0.SND_CH = ch;
    tick(); idle();
  endtask

  task automatic test_reset();
    checks++; if (bus0.MAIN_FULL !== 4'h0) begin errors++; $display("FAIL rst_full got %h want 0", bus0.MAIN_FULL); end
    checks++; if (bus0.SND_PENDING !== 4'h0) begin errors++; $display("FAIL rst_pending got %h want 0", bus0.SND_PENDING); end
    checks++; if (bus0.OVF !== 4'h0) begin errors++; $display("FAIL rst_ovf got %h want 0", bus0.OVF); end
    checks++; if (bus0.REPLY_VALID !== 4'h0) begin errors++; $display("FAIL rst_rvalid got %h want 0", bus0.REPLY_VALID); end
    checks++; if (bus0.MAIN_DOUT !== 8'h00) begin errors++; $display("FAIL rst_main_dout got %h want 00", bus0.MAIN_DOUT); end
    checks++; if (bus0.SND_DOUT !== 8'h00) begin errors++; $display("FAIL rst_snd_dout got %h want 00", bus0.SND_DOUT); end
    checks++; if (bus0.Z80INT !== 1'b0 || bus1.Z80INT !== 1'b0) begin errors++; $display("FAIL rst_int got %b/%b want 0/0", bus0.Z80INT, bus1.Z80INT); end
  endtask

  task automatic test_single();
    push0(2'd2, 8'hA5);
    checks++; if (bus0.SND_PENDING !== 4'b0100) begin errors++; $display("FAIL single_pending got %b want 0100", bus0.SND_PENDING); end
    checks++; if (bus0.Z80INT !== 1'b1) begin errors++; $display("FAIL single_int_set got %b want 1", bus0.Z80INT); end
    pop0(2'd2);
    checks++; if (bus0.SND_DOUT !== 8'hA5) begin errors++; $display("FAIL single_dout got %h want a5", bus0.SND_DOUT); end
    checks++; if (bus0.SND_PENDING !== 4'b0000) begin errors++; $display("FAIL single_drained got %b want 0000", bus0.SND_PENDING); end
    checks++; if (bus0.Z80INT !== 1'b0) begin errors++; $display("FAIL single_int_clr got %b want 0", bus0.Z80INT); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 1; i <= 4; i++) push0(2'd0, 8'(i));
    checks++; if (bus0.MAIN_FULL !== 4'b0001) begin errors++; $display("FAIL ovf_full got %b want 0001", bus0.MAIN_FULL); end
    checks++; if (bus0.OVF !== 4'b0000) begin errors++; $display("FAIL ovf_early got %b want 0000", bus0.OVF); end
    push0(2'd0, 8'h05);
    checks++; if (bus0.OVF !== 4'b0001) begin errors++; $display("FAIL ovf_set got %b want 0001", bus0.OVF); end
    for (int i = 0; i < 4; i++) begin
      pop0(2'd0);
      checks++; if (bus0.SND_DOUT !== exp[i]) begin errors++; $display("FAIL ovf_pop%0d got %h want %h", i, bus0.SND_DOUT, exp[i]); end
    end
    checks++; if (bus0.MAIN_FULL !== 4'b0000) begin errors++; $display("FAIL ovf_notfull got %b want 0000", bus0.MAIN_FULL); end
    pop0(2'd0);
    checks++; if (bus0.SND_DOUT !== 8'h04) begin errors++; $display("FAIL ovf_empty_pop got %h want 04", bus0.SND_DOUT); end
    checks++; if (bus0.SND_PENDING !== 4'b0000) begin errors++; $display("FAIL ovf_empty_pending got %b want 0000", bus0.SND_PENDING); end
    bus0.OVF_CLR = 1; tick(); idle();
    checks++; if (bus0.OVF !== 4'b0000) begin errors++; $display("FAIL ovf_clr got %b want 0000", bus0.OVF); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [4] = '{8'h11, 8'h12, 8'h13, 8'h77};
    for (int i = 0; i < 4; i++) push0(2'd1, 8'h10 + 8'(i));
    bus0.MAIN_WE = 1; bus0.MAIN_CH = 2'd1; bus0.MAIN_DIN = 8'h77;
    bus0.SND_RD = 1; bus0.SND_CH = 2'd1;
    tick(); idle();
    checks++; if (bus0.SND_DOUT !== 8'h10) begin errors++; $display("FAIL fpp_oldest got %h want 10", bus0.SND_DOUT); end
    checks++; if (bus0.OVF !== 4'b0000) begin errors++; $display("FAIL fpp_no_ovf got %b want 0000", bus0.OVF); end
    checks++; if (bus0.MAIN_FULL !== 4'b0010) begin errors++; $display("FAIL fpp_still_full got %b want 0010", bus0.MAIN_FULL); end
    for (int i = 0; i < 4; i++) begin
      pop0(2'd1);
      checks++; if (bus0.SND_DOUT !== exp[i]) begin errors++; $display("FAIL fpp_pop%0d got %h want %h", i, bus0.SND_DOUT, exp[i]); end
    end
    checks++; if (bus0.SND_PENDING !== 4'b0000) begin errors++; $display("FAIL fpp_drained got %b want 0000", bus0.SND_PENDING); end
    // push + pop on an empty channel
    bus0.MAIN_WE = 1; bus0.MAIN_CH = 2'd3; bus0.MAIN_DIN = 8'h55;
    bus0.SND_RD = 1; bus0.SND_CH = 2'd3;
    tick(); idle();
    checks++; if (bus0.SND_DOUT !== 8'h77) begin errors++; $display("FAIL epp_hold got %h want 77", bus0.SND_DOUT); end
    checks++; if (bus0.SND_PENDING !== 4'b1000) begin errors++; $display("FAIL epp_pending got %b want 1000", bus0.SND_PENDING); end
    pop0(2'd3);
    checks++; if (bus0.SND_DOUT !== 8'h55) begin errors++; $display("FAIL epp_pop got %h want 55", bus0.SND_DOUT); end
    // overflowing push wins over a simultaneous clear
    for (int i = 0; i < 4; i++) push0(2'd0, 8'h20 + 8'(i));
    bus0.MAIN_WE = 1; bus0.MAIN_CH = 2'd0; bus0.MAIN_DIN = 8'h99; bus0.OVF_CLR = 1;
    tick(); idle();
    checks++; if (bus0.OVF !== 4'b0001) begin errors++; $display("FAIL ovf_clr_race got %b want 0001", bus0.OVF); end
    bus0.OVF_CLR = 1; tick(); idle();
    checks++; if (bus0.OVF !== 4'b0000) begin errors++; $display("FAIL ovf_clr2 got %b want 0000", bus0.OVF); end
  endtask

  task automatic test_reply();
    bus0.SND_WE = 1; bus0.SND_CH = 2'd3; bus0.SND_DIN = 8'h3C; tick(); idle();
    checks++; if (bus0.REPLY_VALID !== 4'b1000) begin errors++; $display("FAIL rep_valid got %b want 1000", bus0.REPLY_VALID); end
    bus0.MAIN_RD = 1; bus0.MAIN_CH = 2'd3; tick(); idle();
    checks++; if (bus0.MAIN_DOUT !== 8'h3C) begin errors++; $display("FAIL rep_data got %h want 3c", bus0.MAIN_DOUT); end
    checks++; if (bus0.REPLY_VALID !== 4'b0000) begin errors++; $display("FAIL rep_cleared got %b want 0000", bus0.REPLY_VALID); end
    bus0.SND_WE = 1; bus0.SND_CH = 2'd3; bus0.SND_DIN = 8'h5A; tick(); idle();
    bus0.SND_WE = 1; bus0.SND_CH = 2'd3; bus0.SND_DIN = 8'h99;
    bus0.MAIN_RD = 1; bus0.MAIN_CH = 2'd3; tick(); idle();
    checks++; if (bus0.MAIN_DOUT !== 8'h5A) begin errors++; $display("FAIL rep_race_old got %h want 5a", bus0.MAIN_DOUT); end
    checks++; if (bus0.REPLY_VALID !== 4'b1000) begin errors++; $display("FAIL rep_race_valid got %b want 1000", bus0.REPLY_VALID); end
    bus0.MAIN_RD = 1; bus0.MAIN_CH = 2'd3; tick(); idle();
    checks++; if (bus0.MAIN_DOUT !== 8'h99) begin errors++; $display("FAIL rep_race_new got %h want 99", bus0.MAIN_DOUT); end
  endtask

  task automatic test_int_pulse();
    bus1.MAIN_WE = 1; bus1.MAIN_CH = 2'd0; bus1.MAIN_DIN = 8'h01; tick(); idle();
    checks++; if (bus1.Z80INT !== 1'b1) begin errors++; $display("FAIL pulse_set got %b want 1", bus1.Z80INT); end
    bus1.MAIN_WE = 1; bus1.MAIN_CH = 2'd1; bus1.MAIN_DIN = 8'h02; bus1.INT_ACK = 1; tick(); idle();
    checks++; if (bus1.Z80INT !== 1'b1) begin errors++; $display("FAIL pulse_ack_push got %b want 1", bus1.Z80INT); end
    bus1.INT_ACK = 1; tick(); idle();
    checks++; if (bus1.Z80INT !== 1'b0) begin errors++; $display("FAIL pulse_ack got %b want 0", bus1.Z80INT); end
    checks++; if (bus1.SND_PENDING !== 4'b0011) begin errors++; $display("FAIL pulse_pending got %b want 0011", bus1.SND_PENDING); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push0(2'd2, 8'hC0 + 8'(i));
    checks++; if (bus0.SND_PENDING !== 4'b0101) begin errors++; $display("FAIL mid_pre got %b want 0101", bus0.SND_PENDING); end
    #2 rst_n = 0;
    #1;
    checks++; if (bus0.SND_PENDING !== 4'h0 || bus1.SND_PENDING !== 4'h0) begin errors++; $display("FAIL mid_pending got %b/%b want 0", bus0.SND_PENDING, bus1.SND_PENDING); end
    checks++; if (bus0.MAIN_FULL !== 4'h0) begin errors++; $display("FAIL mid_full got %b want 0", bus0.MAIN_FULL); end
    checks++; if (bus0.OVF !== 4'h0) begin errors++; $display("FAIL mid_ovf got %b want 0", bus0.OVF); end
    checks++; if (bus0.Z80INT !== 1'b0 || bus1.Z80INT !== 1'b0) begin errors++; $display("FAIL mid_int got %b/%b want 0", bus0.Z80INT, bus1.Z80INT); end
    tick(); rst_n = 1; tick();
    pop0(2'd2);
    checks++; if (bus0.SND_DOUT !== 8'h00) begin errors++; $display("FAIL mid_discard got %h want 00", bus0.SND_DOUT); end
  endtask

  initial begin
    idle();
    bus0.MAIN_CH = 0; bus0.MAIN_DIN = 0; bus0.SND_CH = 0; bus0.SND_DIN = 0;
    bus1.MAIN_CH = 0; bus1.MAIN_DIN = 0; bus1.SND_CH = 0; bus1.SND_DIN = 0;
    repeat (3) tick();
    test_reset();
    rst_n = 1;
    tick();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_reply();
    test_int_pulse();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raizing_soundlatch_fifo.md
Name: raizing_soundlatch_fifo

Overview:
Parametrised main-CPU to sound-CPU mailbox. It is the successor to the single 8-bit SOUNDLATCH path between the 68K and the Z80.
- Provides NCH independent command FIFOs (68K to Z80), each DEPTH entries deep.
- Provides NCH reply registers (Z80 to 68K) with valid flags.
- Generates the Z80 interrupt.
- Sits between the game CPU module and the game sound module, clocked on the 48 MHz domain.

Parameters:
NCH, 4, number of channels (1..8)
DEPTH, 4, FIFO entries per channel (power of two, 2..16)
INT_PULSE, 0, 0 = Z80INT is a level (OR of pending); 1 = Z80INT is latched, set on each push, cleared by INT_ACK

Ports:
CLK  in  1  system clock (48 MHz domain)
RESET  in  1  asynchronous, active-low reset
MAIN_WE  in  1  68K push strobe, one cycle
MAIN_CH  in  $clog2(NCH)  channel for push and reply read
MAIN_DIN  in  8  command byte
MAIN_RD  in  1  68K reply-read strobe, one cycle
MAIN_DOUT  out  8  reply byte, registered
MAIN_FULL  out  NCH  per-channel FIFO full
REPLY_VALID  out  NCH  per-channel reply pending
SND_RD  in  1  Z80 pop strobe, one cycle
SND_CH  in  $clog2(NCH)  channel for pop and reply write
SND_DOUT  out  8  popped byte, registered
SND_WE  in  1  Z80 reply write strobe
SND_DIN  in  8  reply byte
SND_PENDING  out  NCH  per-channel FIFO non-empty
OVF  out  NCH  sticky overflow flags
OVF_CLR  in  1  clears all OVF bits
INT_ACK  in  1  Z80 interrupt acknowledge
Z80INT  out  1  active-high interrupt request to the sound CPU

Behaviour:
- Reset (RESET low, asynchronous):
  - All pointers and counts 0; all outputs 0.
  - MAIN_DOUT and SND_DOUT = 8'h00.
  - Release is synchronous to CLK in the normal way. Asserting reset mid-transfer discards all FIFO contents.
- Push (MAIN_WE):
  - Writes MAIN_DIN at the write pointer of MAIN_CH; count +1.
  - MAIN_FULL and SND_PENDING update the cycle after the edge.
  - If the channel is full, the byte is dropped, the pointer is unchanged, and OVF[ch] is set.
- Pop (SND_RD):
  - SND_DOUT = head of SND_CH, valid one cycle after the strobe; read pointer +1.
  - If the channel is empty, SND_DOUT holds its previous value and no state changes (no underflow flag).
- Same channel, same cycle:
  - Push + pop both take effect and count is unchanged.
  - Push + pop on a full channel: the pop proceeds and the push is accepted; OVF is not set.
  - Push + pop on an empty channel: the pop returns the old SND_DOUT; the new byte is enqueued and count = 1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- Reply path:
  - SND_WE writes reply[SND_CH] and sets REPLY_VALID[SND_CH]. An overwrite while valid replaces the data.
  - MAIN_RD loads MAIN_DOUT = reply[MAIN_CH] next cycle and clears REPLY_VALID[MAIN_CH].
  - If MAIN_RD and SND_WE hit the same channel in the same cycle, the old reply is returned and valid stays 1 with the new data.
- Interrupt:
  - INT_PULSE=0: Z80INT = |SND_PENDING, registered.
  - INT_PULSE=1: Z80INT is set on any accepted push and cleared by INT_ACK. Accepted push + INT_ACK in the same cycle leaves it set.
- OVF_CLR together with an overflowing push: OVF ends set.

Optional Feature:
SOUNDLATCH_NMI_EN
- Defined: adds output Z80NMI (1 bit). It is a one-cycle pulse on every accepted push to channel NCH-1, registered, and independent of INT_PULSE. Channel NCH-1 is reserved for urgent commands such as sound reset.
- Undefined: the port and its logic are absent, and channel NCH-1 behaves like any other channel.

Decomposition:
- Package raizing_soundlatch_pkg holds:
  - function ch_w(n) returning $clog2 with a minimum of 1
  - localparam byte type width 8
  - the reset constant 8'h00
- One sub-module: raizing_latch_chfifo, a single-channel DEPTH x 8 FIFO with push, pop, full, empty, ovf and registered dout. It is instantiated NCH times via generate.
- The top level does channel decode, output muxing, reply registers and interrupt logic.

Test Plan:
- Reset, then push 8'hA5 on ch2; pop ch2 → SND_PENDING[2] goes 1 then 0; SND_DOUT=8'hA5 one cycle after pop; Z80INT follows pending (INT_PULSE=0).
- Push 5 bytes 01..05 to ch0 with DEPTH=4 → MAIN_FULL[0]=1 after the 4th; OVF[0]=1; pops return 01,02,03,04; 5th pop leaves SND_DOUT=04.
- Full ch1: simultaneous push 8'h77 and pop → pop returns oldest; OVF[1]=0; count stays 4; 8'h77 emerges last.
- SND_WE ch3 8'h3C, then MAIN_RD ch3 → MAIN_DOUT=8'h3C; REPLY_VALID[3] 1→0. Repeat with same-cycle SND_WE 8'h99 → old value read, valid stays 1.
- INT_PULSE=1: push, then INT_ACK together with a second push → Z80INT stays 1; a lone INT_ACK → 0.
- Assert RESET low mid-stream with 3 bytes queued → all pending, full and OVF flags 0 immediately, without waiting for a clock; Z80INT=0.
